lock_requester: RTL and testbench
=================================

// Module: lock_requester
// PURPOSE
//  Accelerator-side client of the lock manager: turns lock/unlock requests from an accelerator
//  core into 64-bit lock commands, and consumes the 8-bit grant/deny acks.
//  A denied lock (ack 0) is retried after a programmable backoff until granted.
//  Sits between one accelerator and the lock manager's command/ack AXI-Stream ports.
// PARAMETERS
//  ACC_ID      4'd0   TID driven on cmdStream; manager routes the ack back to TDEST==ACC_ID
//  LOCK_ID_W   8      lock-ID width; placed in cmd TDATA[8 +: LOCK_ID_W]
//  BACKOFF     16     idle cycles between a deny and the retry (>=1)
// PORTS
//  clk               in   1   clock
//  rst               in   1   synchronous, active-high reset
//  req_valid         in   1   accelerator request valid
//  req_ready         out  1   request accepted when req_valid & req_ready
//  req_op            in   1   0 = lock, 1 = unlock
//  req_lock_id       in   LOCK_ID_W  target lock
//  done              out  1   1-cycle pulse: lock granted, or unlock command handshaken
//  cmdStream_TDATA   out  64  [7:0] opcode (0x04 lock, 0x06 unlock), [8+:LOCK_ID_W] id, rest 0
//  cmdStream_TVALID  out  1
//  cmdStream_TREADY  in   1
//  cmdStream_TID     out  4   constant ACC_ID
//  ackStream_TDATA   in   8   8'h01 granted, 8'h00 denied
//  ackStream_TVALID  in   1
//  ackStream_TREADY  out  1
//  retry_cnt         out  16  denies seen for the current/last lock request, saturating
//  err_unexp_ack     out  1   sticky: ack received outside WAIT_ACK, or TDATA not 0/1
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state IDLE; req_ready=1, done=0, cmdStream_TVALID=0,
//   cmdStream_TDATA=0, ackStream_TREADY=0, retry_cnt=0, err_unexp_ack=0. Reset mid-transfer
//   drops the in-flight command/ack with no replay. An ack that arrives after reset is
//   flagged unexpected.
//  FSM: IDLE -> SEND -> (lock) WAIT_ACK -> {DONE | BACKOFF -> SEND}; (unlock) SEND -> DONE -> IDLE.
//  IDLE: req_ready=1. On accept, register op and id, clear retry_cnt, go to SEND.
//   cmdStream_TVALID rises the next cycle (1-cycle latency).
//  SEND: TVALID held and TDATA stable until TREADY. No combinational path from TREADY
//   to TVALID. Handshake on a lock -> WAIT_ACK; on an unlock -> DONE.
//  WAIT_ACK: ackStream_TREADY=1.
//   - Ack 8'h01 -> DONE.
//   - Ack 8'h00 -> retry_cnt+1 (saturate at 16'hFFFF), load backoff counter with BACKOFF, go to BACKOFF.
//   - Any other value -> set err_unexp_ack and treat as a deny.
//  BACKOFF: count down to 1, then SEND with the same registered command (a new TVALID).
//  DONE: done=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE.
//  ackStream_TREADY=1 in IDLE, SEND, BACKOFF and DONE as well. Acks there are consumed,
//   discarded and set err_unexp_ack, so a stray ack never stalls the manager.
//  Unlock expects no ack. The state returns to IDLE two cycles after the cmd handshake.
//  Minimum lock latency: accept (cycle 0) -> TVALID (1) -> handshake (>=1) -> ack (>=2) -> done (+1).
//  retry_cnt holds its value after DONE until the next accepted request.
// STRUCTURE
//  Shared package lock_pkg: LOCK_OPC_LOCK=8'h04, LOCK_OPC_UNLOCK=8'h06, ACK_GRANT=8'h01,
//   ACK_DENY=8'h00, and a typedef enum for the FSM state.
//   The lock manager imports the same package.
//  No sub-module: the FSM, a BACKOFF down-counter and the command register stay inline.
// TESTING
//  1 Lock id 0, ACC_ID=0. Cmd TREADY=1; ack 8'h01 two cycles later.
//    -> TDATA=64'h04, TID=0; done pulses once; retry_cnt=0.
//  2 Lock id 3. Ack 8'h00, then 8'h01.
//    -> second cmd TVALID exactly BACKOFF+1 cycles after the deny; TDATA=64'h0304 both times;
//       retry_cnt=1.
//  3 Unlock id 0.
//    -> TDATA=64'h06; done 1 cycle after the handshake; no ack consumed; err_unexp_ack=0.
//  4 TREADY held low for 10 cycles.
//    -> TVALID and TDATA stable throughout; req_ready=0; one handshake only.
//  5 Stray ack 8'h01 while IDLE.
//    -> consumed the same cycle; err_unexp_ack=1; no done.
//  6 rst=1 during WAIT_ACK, then a fresh lock.
//    -> all outputs at reset values; the new request is handled as in scenario 1.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared lock protocol constants and requester FSM types.
// Imported by both the lock requester and the lock manager.
package lock_pkg;

   localparam logic [7:0] LOCK_OPC_LOCK   = 8'h04;
   localparam logic [7:0] LOCK_OPC_UNLOCK = 8'h06;
   localparam logic [7:0] ACK_GRANT       = 8'h01;
   localparam logic [7:0] ACK_DENY        = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_ACK,
      ST_BACKOFF,
      ST_DONE
   } lock_state_e;

   typedef enum logic {
      OP_LOCK   = 1'b0,
      OP_UNLOCK = 1'b1
   } lock_op_e;

endpackage

// File: rtl/lock_requester_if.sv
// Accelerator request port plus the command/ack streams of the lock requester.
// master = the requester, slave = accelerator/manager side.
interface lock_requester_if #(
   parameter int LOCK_ID_W = 8
) ();

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_op;
   logic [LOCK_ID_W-1:0] req_lock_id;
   logic                 done;

   logic [63:0]          cmdStream_TDATA;
   logic                 cmdStream_TVALID;
   logic                 cmdStream_TREADY;
   logic [3:0]           cmdStream_TID;

   logic [7:0]           ackStream_TDATA;
   logic                 ackStream_TVALID;
   logic                 ackStream_TREADY;

   logic [15:0]          retry_cnt;
   logic                 err_unexp_ack;

   modport master (
      input  req_valid, req_op, req_lock_id,
      output req_ready, done,
      output cmdStream_TDATA, cmdStream_TVALID, cmdStream_TID,
      input  cmdStream_TREADY,
      input  ackStream_TDATA, ackStream_TVALID,
      output ackStream_TREADY,
      output retry_cnt, err_unexp_ack
   );

   modport slave (
      output req_valid, req_op, req_lock_id,
      input  req_ready, done,
      input  cmdStream_TDATA, cmdStream_TVALID, cmdStream_TID,
      output cmdStream_TREADY,
      output ackStream_TDATA, ackStream_TVALID,
      input  ackStream_TREADY,
      input  retry_cnt, err_unexp_ack
   );

endinterface

// File: rtl/lock_requester.sv
// Accelerator-side lock client: issues lock/unlock commands and
// retries denied locks after a fixed backoff until granted.
module lock_requester
   import lock_pkg::*;
#(
   parameter logic [3:0] ACC_ID    = 4'd0,
   parameter int         LOCK_ID_W = 8,
   parameter int         BACKOFF   = 16
) (
   input logic              clk,
   input logic              rst,
   lock_requester_if.master bus
);

   lock_state_e state_q, state_d;
   lock_op_e    op_q, op_d;
   logic [63:0] cmd_q, cmd_d;
   logic [15:0] retry_q, retry_d;
   logic [15:0] bo_q, bo_d;
   logic        err_q, err_d;

   logic [63:0] cmd_new;
   logic        ack_rdy;
   logic        ack_fire;
   logic        ack_bad;

   // Acks are always drained so a stray one never back-pressures the manager.
   assign ack_rdy  = ~rst;
   assign ack_fire = bus.ackStream_TVALID & ack_rdy;
   assign ack_bad  = (bus.ackStream_TDATA != ACK_GRANT) &&
                     (bus.ackStream_TDATA != ACK_DENY);

   always_comb begin
      cmd_new        = '0;
      cmd_new[7:0]   = bus.req_op ? LOCK_OPC_UNLOCK : LOCK_OPC_LOCK;
      cmd_new[8 +: LOCK_ID_W] = bus.req_lock_id;

      state_d = state_q;
      op_d    = op_q;
      cmd_d   = cmd_q;
      retry_d = retry_q;
      bo_d    = bo_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op_d    = lock_op_e'(bus.req_op);
               cmd_d   = cmd_new;
               retry_d = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bus.cmdStream_TREADY) begin
               state_d = (op_q == OP_LOCK) ? ST_WAIT_ACK : ST_DONE;
            end
         end
         ST_WAIT_ACK: begin
            if (ack_fire) begin
               if (bus.ackStream_TDATA == ACK_GRANT) begin
                  state_d = ST_DONE;
               end else begin
                  if (retry_q != 16'hFFFF) begin
                     retry_d = retry_q + 16'd1;
                  end
                  bo_d    = 16'(BACKOFF);
                  state_d = ST_BACKOFF;
               end
            end
         end
         ST_BACKOFF: begin
            if (bo_q <= 16'd1) begin
               state_d = ST_SEND;
            end else begin
               bo_d = bo_q - 16'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (ack_fire && ((state_q != ST_WAIT_ACK) || ack_bad)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOCK;
         cmd_q   <= '0;
         retry_q <= '0;
         bo_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cmd_q   <= cmd_d;
         retry_q <= retry_d;
         bo_q    <= bo_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready        = (state_q == ST_IDLE);
   assign bus.done             = (state_q == ST_DONE);
   assign bus.cmdStream_TVALID = (state_q == ST_SEND);
   assign bus.cmdStream_TDATA  = cmd_q;
   assign bus.cmdStream_TID    = ACC_ID;
   assign bus.ackStream_TREADY = ack_rdy;
   assign bus.retry_cnt        = retry_q;
   assign bus.err_unexp_ack    = err_q;

endmodule

// File: tb/tb_lock_requester.sv
// Randomized bench for lock_requester; the bench plays accelerator and
// lock manager and predicts each transaction from the protocol rules.
module tb_lock_requester;

   localparam logic [3:0] ACC_ID  = 4'd0;
   localparam int         IDW     = 8;
   localparam int         BACKOFF = 16;

   logic clk;
   logic rst;

   lock_requester_if #(.LOCK_ID_W(IDW)) bus ();

   lock_requester #(
      .ACC_ID   (ACC_ID),
      .LOCK_ID_W(IDW),
      .BACKOFF  (BACKOFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp;
   int n_bad;
   int exp_done;
   int done_seen;
   int exp_hs;
   int hs_seen;
   bit exp_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && bus.done) done_seen++;
   end

   always @(posedge clk) begin
      if (!rst && bus.cmdStream_TVALID && bus.cmdStream_TREADY) hs_seen++;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full accelerator request with the manager answering n_deny
   // denies then a grant.
   task automatic do_req(input bit op, input logic [IDW-1:0] id,
                         input int n_deny, input int stall,
                         input int ack_dly, input bit bad);
      logic [63:0] exp_cmd;
      int          c;
      bit          stable;
      int          tries;
      exp_cmd = (64'(id) << 8) | (op ? 64'h06 : 64'h04);
      tries   = op ? 1 : n_deny + 1;
      c = 0;
      while (!bus.req_ready && c < 50) begin
         tick();
         c++;
      end
      if (c >= 50) begin
         chk("req_ready_timeout", 64'd0, 64'd1);
         return;
      end
      bus.req_valid   = 1'b1;
      bus.req_op      = op;
      bus.req_lock_id = id;
      tick();
      bus.req_valid = 1'b0;
      chk("tvalid_latency", 64'(bus.cmdStream_TVALID), 64'd1);
      for (int a = 0; a < tries; a++) begin
         stable = 1'b1;
         for (int s = 0; s < stall; s++) begin
            if (!bus.cmdStream_TVALID || bus.cmdStream_TDATA !== exp_cmd ||
                bus.req_ready) stable = 1'b0;
            tick();
         end
         if (stall > 0) chk("stall_stable", 64'(stable), 64'd1);
         chk("cmd_tdata", bus.cmdStream_TDATA, exp_cmd);
         chk("cmd_tid", 64'(bus.cmdStream_TID), 64'(ACC_ID));
         bus.cmdStream_TREADY = 1'b1;
         tick();
         bus.cmdStream_TREADY = 1'b0;
         exp_hs++;
         if (op) begin
            chk("unlock_done", 64'(bus.done), 64'd1);
            exp_done++;
            tick();
            chk("unlock_idle", 64'(bus.req_ready), 64'd1);
         end else begin
            for (int d = 0; d < ack_dly; d++) tick();
            bus.ackStream_TVALID = 1'b1;
            if (a < n_deny) begin
               if (bad && a == 0) begin
                  bus.ackStream_TDATA = 8'($urandom_range(2, 255));
                  exp_err = 1'b1;
               end else begin
                  bus.ackStream_TDATA = 8'h00;
               end
            end else begin
               bus.ackStream_TDATA = 8'h01;
            end
            chk("ack_tready", 64'(bus.ackStream_TREADY), 64'd1);
            tick();
            bus.ackStream_TVALID = 1'b0;
            if (a < n_deny) begin
               c = 0;
               while (!bus.cmdStream_TVALID && c < 200) begin
                  tick();
                  c++;
               end
               chk("backoff_gap", 64'(c + 1), 64'(BACKOFF + 1));
            end else begin
               chk("lock_done", 64'(bus.done), 64'd1);
               exp_done++;
               tick();
               chk("done_one_cycle", 64'(bus.done), 64'd0);
               chk("retry_cnt", 64'(bus.retry_cnt), 64'(n_deny));
            end
         end
      end
      chk("err_flag", 64'(bus.err_unexp_ack), 64'(exp_err));
   endtask

   task automatic chk_reset_vals();
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_tvalid", 64'(bus.cmdStream_TVALID), 64'd0);
      chk("rst_tdata", bus.cmdStream_TDATA, 64'd0);
      chk("rst_ack_tready", 64'(bus.ackStream_TREADY), 64'd0);
      chk("rst_retry", 64'(bus.retry_cnt), 64'd0);
      chk("rst_err", 64'(bus.err_unexp_ack), 64'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      exp_done = 0;
      done_seen = 0;
      exp_hs = 0;
      hs_seen = 0;
      exp_err = 1'b0;
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op = 1'b0;
      bus.req_lock_id = '0;
      bus.cmdStream_TREADY = 1'b0;
      bus.ackStream_TVALID = 1'b0;
      bus.ackStream_TDATA = 8'h00;
      tick();
      tick();
      chk_reset_vals();
      rst = 1'b0;
      tick();

      do_req(1'b0, 8'd0, 0, 0, 1, 1'b0);
      do_req(1'b0, 8'd3, 1, 0, 1, 1'b0);
      do_req(1'b1, 8'd0, 0, 0, 0, 1'b0);
      do_req(1'b0, 8'd9, 0, 10, 0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      end

      // stray grant while idle
      bus.ackStream_TVALID = 1'b1;
      bus.ackStream_TDATA  = 8'h01;
      chk("stray_tready", 64'(bus.ackStream_TREADY), 64'd1);
      tick();
      bus.ackStream_TVALID = 1'b0;
      exp_err = 1'b1;
      chk("stray_err", 64'(bus.err_unexp_ack), 64'd1);
      chk("stray_no_done", 64'(bus.done), 64'd0);

      // reset while waiting for an ack
      bus.req_valid   = 1'b1;
      bus.req_op      = 1'b0;
      bus.req_lock_id = 8'd5;
      tick();
      bus.req_valid = 1'b0;
      bus.cmdStream_TREADY = 1'b1;
      tick();
      bus.cmdStream_TREADY = 1'b0;
      exp_hs++;
      tick();
      rst = 1'b1;
      tick();
      chk_reset_vals();
      rst = 1'b0;
      exp_err = 1'b0;
      tick();
      do_req(1'b0, 8'd0, 0, 0, 1, 1'b0);

      tick();
      chk("done_count", 64'(done_seen), 64'(exp_done));
      chk("hs_count", 64'(hs_seen), 64'(exp_hs));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

endmodule
